safe_sync_ctrl: RTL and testbench
=================================

# safe_sync_ctrl

Parametrised lockstep-entry controller for the safety subsystem. It halts the non-master cores of a selected group and waits for them to park. It then raises the sync interrupt to every group member and collects per-core acknowledges. Finally it holds the group on the single shared bus until released. It supports N cores, dual or all-core groups, a configurable master, per-phase timeouts with an error state, and an explicit exit path.

## Interface
Parameters:
- NCORES, 3, number of cores served (≥2)
- TIMEOUT_CYCLES, 1024, maximum cycles allowed in each waiting phase (≥2)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, reset is synchronous and active-high
- start_i  in  1  sync request from master core; sampled in IDLE only
- mode_i  in  2  group select: 00 single (no sync), 01 dual, 10 all cores, 11 reserved
- master_id_i  in  $clog2(NCORES)  index of requesting core
- halted_i  in  NCORES  per-core "parked in wait loop" level
- intc_ack_i  in  NCORES  per-core sync-interrupt acknowledge
- exit_i  in  1  leave LOCKED or ERROR
- halt_irq_o  out  NCORES  halt interrupt, one-cycle pulse
- sync_irq_o  out  NCORES  sync interrupt, per-core level
- single_bus_o  out  1  group runs on shared bus
- group_mask_o  out  NCORES  latched participant mask
- busy_o  out  1  sequence in progress (HALT..INTR_SYNC)
- locked_o  out  1  group in lockstep
- err_o  out  1  timeout error

## Operation
- States: IDLE, HALT, WAIT_HALT, INTR_SYNC, LOCKED, ERROR. Moore outputs decoded from registered state and registered masks.
- IDLE: start_i=1 with mode_i∈{01,10} and master_id_i<NCORES → latch master and group mask → HALT. Any other start_i is ignored and the block stays in IDLE.
- Group mask: dual = bits master and (master+1) mod NCORES; all = all ones.
- HALT (1 cycle): halt_irq_o = group mask with master bit cleared → WAIT_HALT.
- WAIT_HALT: accumulate sticky halted mask from halted_i & slaves. When all slaves are recorded, or when halted_i covers them in the current cycle → INTR_SYNC.
- INTR_SYNC: single_bus_o=1. sync_irq_o[i] = group[i] & ~acked[i]. Accumulate sticky acked mask from intc_ack_i. When all group bits are acked, including via the current-cycle ack → LOCKED.
- LOCKED: single_bus_o=1, locked_o=1. start_i is ignored. exit_i → IDLE.
- ERROR: err_o=1. All irqs and single_bus_o are 0. exit_i → IDLE.
- Timeout: a cycle counter clears on entry to WAIT_HALT and to INTR_SYNC, and increments each cycle in those states. When count = TIMEOUT_CYCLES-1 and the phase is incomplete → ERROR. If completion and timeout occur in the same cycle, completion wins.
- Sticky masks clear on entry to HALT. Acks and halted bits from non-group cores are ignored.
- group_mask_o holds its value through LOCKED and ERROR, and clears on return to IDLE.
- rst_i at any point → IDLE next edge. All masks and counters are cleared and all outputs are 0, regardless of current state.

## Timing
- Reset values: every output 0; state IDLE.
- start_i at cycle t → halt_irq_o high during t+1 only; WAIT_HALT from t+2.
- Final halted bit at cycle u → sync_irq_o and single_bus_o high from u+1.
- intc_ack_i[i] at cycle v → sync_irq_o[i] low from v+1. If it completes the set, LOCKED from v+1.
- exit_i at cycle w in LOCKED/ERROR → all outputs 0 from w+1. A start_i is accepted from w+1 onward.
- Counter width is $clog2(TIMEOUT_CYCLES). It never wraps, because it stops on leaving the phase.
- Worst-case entry to ERROR: exactly TIMEOUT_CYCLES cycles after entering the phase.

## Structure
- Package safe_sync_pkg holds the state enum (safe_sync_state_e), the mode enum (safe_sync_mode_e), and the group-mask function.
- Sub-module safe_sync_timer: clear/enable inputs, expire output, parameter TIMEOUT_CYCLES. Used once and shared by both wait phases.

## Test plan
- NCORES=3, mode 01, master 1: start → halt_irq_o=3'b100 for one cycle. halted_i[2] after 5 cycles → sync_irq_o=3'b110. Acks 1 then 2 → per-core drop, LOCKED, single_bus_o=1. exit_i → all 0.
- Mode 10, master 0: halted_i bits arrive on different cycles → INTR_SYNC only after the last bit. Simultaneous ack of all three → LOCKED next cycle.
- TIMEOUT_CYCLES=8, no halted_i → err_o rises 8 cycles after WAIT_HALT entry and sync_irq_o never asserts. exit_i → IDLE.
- Last ack on the timeout cycle → LOCKED, err_o stays 0.
- Ignored requests: mode 00, mode 11, or master_id 3 with NCORES=3 → stays IDLE, outputs 0. start_i in LOCKED → no change.
- rst_i asserted in INTR_SYNC → next cycle all outputs 0, state IDLE, and a new start_i behaves as in the first scenario.

Source files
------------

// File: rtl/safe_sync_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// safe_sync_pkg : state/mode types and group-mask helper  | Rev 1.0
// ------------------------------------------------------------------
package safe_sync_pkg;

  localparam int MAX_CORES = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HALT      = 3'd1,
    ST_WAIT_HALT = 3'd2,
    ST_INTR_SYNC = 3'd3,
    ST_LOCKED    = 3'd4,
    ST_ERROR     = 3'd5
  } safe_sync_state_e;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_DUAL   = 2'b01,
    MODE_ALL    = 2'b10,
    MODE_RSVD   = 2'b11
  } safe_sync_mode_e;

  // Dual pairs the master with its successor (wrapping); all selects every core.
  function automatic logic [MAX_CORES-1:0] group_mask(safe_sync_mode_e mode,
                                                       int unsigned master,
                                                       int unsigned ncores);
    logic [MAX_CORES-1:0] mask;
    logic [63:0]          all_ones;
    mask     = '0;
    all_ones = (64'd1 << ncores) - 64'd1;
    case (mode)
      MODE_DUAL: mask = (MAX_CORES'(1) << master) |
                        (MAX_CORES'(1) << ((master + 1) % ncores));
      MODE_ALL:  mask = all_ones[MAX_CORES-1:0];
      default:   mask = '0;
    endcase
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/safe_sync_ctrl_if.sv
`default_nettype none
// ------------------------------------------------------------------
// safe_sync_ctrl_if : request/handshake bundle of safe_sync_ctrl | Rev 1.0
// ------------------------------------------------------------------
interface safe_sync_ctrl_if #(
  parameter int NCORES = 3
);
  localparam int MW = (NCORES > 1) ? $clog2(NCORES) : 1;

  logic              start_i;
  logic [1:0]        mode_i;
  logic [MW-1:0]     master_id_i;
  logic [NCORES-1:0] halted_i;
  logic [NCORES-1:0] intc_ack_i;
  logic              exit_i;
  logic [NCORES-1:0] halt_irq_o;
  logic [NCORES-1:0] sync_irq_o;
  logic              single_bus_o;
  logic [NCORES-1:0] group_mask_o;
  logic              busy_o;
  logic              locked_o;
  logic              err_o;

  modport slave (
    input  start_i, mode_i, master_id_i, halted_i, intc_ack_i, exit_i,
    output halt_irq_o, sync_irq_o, single_bus_o, group_mask_o, busy_o, locked_o, err_o
  );

  modport master (
    output start_i, mode_i, master_id_i, halted_i, intc_ack_i, exit_i,
    input  halt_irq_o, sync_irq_o, single_bus_o, group_mask_o, busy_o, locked_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/safe_sync_timer.sv
`default_nettype none
// ------------------------------------------------------------------
// safe_sync_timer : saturating phase timeout counter       | Rev 1.0
// ------------------------------------------------------------------
module safe_sync_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int            CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Holds at LAST so the counter can never wrap while a phase lingers.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = enable && (count == LAST);
endmodule
`default_nettype wire

// File: rtl/safe_sync_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// safe_sync_ctrl : halt -> sync-irq -> lockstep entry controller | Rev 1.0
// ------------------------------------------------------------------
module safe_sync_ctrl #(
  parameter int NCORES         = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  safe_sync_ctrl_if.slave  bus
);
  import safe_sync_pkg::*;

  safe_sync_state_e  state;
  safe_sync_mode_e   req_mode;
  logic [NCORES-1:0] group;
  logic [NCORES-1:0] slaves;
  logic [NCORES-1:0] halted_acc;
  logic [NCORES-1:0] acked_acc;
  logic [NCORES-1:0] halt_irq;
  logic [NCORES-1:0] sync_irq;
  logic              single_bus;
  logic              busy;
  logic              locked;
  logic              err;

  logic [NCORES-1:0] req_mask;
  logic [NCORES-1:0] req_master;
  logic [NCORES-1:0] halted_now;
  logic [NCORES-1:0] acked_now;
  logic              req_ok;
  logic              halt_done;
  logic              ack_done;
  logic              tmr_clear;
  logic              tmr_enable;
  logic              expire;

  assign req_mode   = safe_sync_mode_e'(bus.mode_i);
  assign req_ok     = bus.start_i &&
                      ((req_mode == MODE_DUAL) || (req_mode == MODE_ALL)) &&
                      (32'(bus.master_id_i) < 32'(NCORES));
  assign req_mask   = NCORES'(group_mask(req_mode, 32'(bus.master_id_i), NCORES));
  assign req_master = NCORES'(1) << bus.master_id_i;

  // Completion includes the current-cycle inputs, so it beats a coincident timeout.
  assign halted_now = halted_acc | (bus.halted_i & slaves);
  assign halt_done  = (halted_now == slaves);
  assign acked_now  = acked_acc | (bus.intc_ack_i & group);
  assign ack_done   = (acked_now == group);

  assign tmr_clear  = (state == ST_HALT) || ((state == ST_WAIT_HALT) && halt_done);
  assign tmr_enable = (state == ST_WAIT_HALT) || (state == ST_INTR_SYNC);

  safe_sync_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expire (expire)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      group      <= '0;
      slaves     <= '0;
      halted_acc <= '0;
      acked_acc  <= '0;
      halt_irq   <= '0;
      sync_irq   <= '0;
      single_bus <= 1'b0;
      busy       <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_ok) begin
            group      <= req_mask;
            slaves     <= req_mask & ~req_master;
            halted_acc <= '0;
            acked_acc  <= '0;
            halt_irq   <= req_mask & ~req_master;
            busy       <= 1'b1;
            state      <= ST_HALT;
          end
        end
        ST_HALT: begin
          halt_irq <= '0;
          state    <= ST_WAIT_HALT;
        end
        ST_WAIT_HALT: begin
          halted_acc <= halted_now;
          if (halt_done) begin
            sync_irq   <= group;
            single_bus <= 1'b1;
            state      <= ST_INTR_SYNC;
          end else if (expire) begin
            busy  <= 1'b0;
            err   <= 1'b1;
            state <= ST_ERROR;
          end
        end
        ST_INTR_SYNC: begin
          acked_acc <= acked_now;
          sync_irq  <= group & ~acked_now;
          if (ack_done) begin
            busy   <= 1'b0;
            locked <= 1'b1;
            state  <= ST_LOCKED;
          end else if (expire) begin
            sync_irq   <= '0;
            single_bus <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b1;
            state      <= ST_ERROR;
          end
        end
        ST_LOCKED, ST_ERROR: begin
          if (bus.exit_i) begin
            group      <= '0;
            slaves     <= '0;
            halted_acc <= '0;
            acked_acc  <= '0;
            sync_irq   <= '0;
            single_bus <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.halt_irq_o   = halt_irq;
  assign bus.sync_irq_o   = sync_irq;
  assign bus.single_bus_o = single_bus;
  assign bus.group_mask_o = group;
  assign bus.busy_o       = busy;
  assign bus.locked_o     = locked;
  assign bus.err_o        = err;
endmodule
`default_nettype wire

// File: tb/tb_safe_sync_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_safe_sync_ctrl : timeline-model scoreboard bench      | Rev 1.0
// ------------------------------------------------------------------
module tb_safe_sync_ctrl;
  localparam int NC = 3;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;

  safe_sync_ctrl_if #(.NCORES(NC)) bus ();

  safe_sync_ctrl #(
    .NCORES         (NC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [12:0] v;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  logic [12:0] act;
  logic [12:0] prev_act;
  logic [12:0] prev_exp;
  int          dd[3];
  int          ee[3];

  assign act = {bus.halt_irq_o, bus.sync_irq_o, bus.group_mask_o,
                bus.single_bus_o, bus.busy_o, bus.locked_o, bus.err_o};

  always @(posedge clk) cyc <= cyc + 1;

  // Every output change must match the next expected change, at the expected cycle.
  always @(negedge clk) begin
    if (mon_en && (act !== prev_act)) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change cyc=%0d got=%b (no change expected)", cyc, act);
      end else begin
        mon_e = q.pop_front();
        if ((mon_e.cyc != cyc) || (mon_e.v !== act)) begin
          n_fail++;
          $display("FAIL out_change cyc=%0d got=%b required=%b at cyc=%0d",
                   cyc, act, mon_e.v, mon_e.cyc);
        end
      end
    end
    prev_act = act;
  end

  function automatic logic [12:0] pack(input logic [2:0] h, input logic [2:0] s,
                                       input logic [2:0] g, input logic b,
                                       input logic bz, input logic l, input logic e);
    return {h, s, g, b, bz, l, e};
  endfunction

  // Timeline (relative to the start cycle): HALT at 1, WAIT from 2, sync from p,
  // LOCKED/ERROR from fin, exit at x, idle from x+1.
  task automatic run_scn(input int mode, input int m, input int hold, input int rst_at);
    bit          valid, halt_ok, lock_ok;
    logic [2:0]  g, sl, s;
    logic [12:0] v;
    int          maxd, maxe, p, fin, x, endr, t0, r;
    exp_t        ent;
    valid = ((mode == 1) || (mode == 2)) && (m < NC);
    g = 3'b000;
    if (valid) g = (mode == 2) ? 3'b111 : 3'((1 << m) | (1 << ((m + 1) % NC)));
    sl = g & ~3'(1 << m);
    maxd = 0;
    maxe = 0;
    for (int i = 0; i < NC; i++) begin
      if (sl[i] && dd[i] > maxd) maxd = dd[i];
      if (g[i] && ee[i] > maxe) maxe = ee[i];
    end
    halt_ok = (maxd <= TO - 1);
    lock_ok = halt_ok && (maxe <= TO - 1);
    p = 2 + maxd + 1;
    if (!halt_ok)     fin = 2 + TO;
    else if (lock_ok) fin = p + maxe + 1;
    else              fin = p + TO;
    x = fin + hold;
    endr = valid ? x + 3 : 3;
    if (rst_at >= 0) endr = rst_at + 3;
    t0 = 0;
    for (int k = 0; k < endr; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) t0 = cyc;
      rst = (k == rst_at);
      bus.start_i     = (k == 0) ||
                        (valid && rst_at < 0 && k >= fin && k < x && (k == fin || $urandom_range(0, 2) == 0));
      bus.mode_i      = (k == 0) ? 2'(mode) : 2'($urandom);
      bus.master_id_i = (k == 0) ? 2'(m) : 2'($urandom);
      bus.exit_i      = valid && (k == x);
      for (int i = 0; i < NC; i++) begin
        bus.halted_i[i]   = sl[i] ? (k >= 2 + dd[i]) : 1'($urandom);
        bus.intc_ack_i[i] = g[i] ? (halt_ok && k == p + ee[i]) : 1'($urandom);
      end
      r = k + 1;
      if (!valid || (rst_at >= 0 && r > rst_at) || r > x) v = '0;
      else if (r == 1) v = pack(sl, 3'b0, g, 1'b0, 1'b1, 1'b0, 1'b0);
      else if (r < (halt_ok ? p : fin)) v = pack(3'b0, 3'b0, g, 1'b0, 1'b1, 1'b0, 1'b0);
      else if (r < fin) begin
        for (int i = 0; i < NC; i++) s[i] = g[i] && (r <= p + ee[i]);
        v = pack(3'b0, s, g, 1'b1, 1'b1, 1'b0, 1'b0);
      end
      else if (lock_ok) v = pack(3'b0, 3'b0, g, 1'b1, 1'b0, 1'b1, 1'b0);
      else v = pack(3'b0, 3'b0, g, 1'b0, 1'b0, 1'b0, 1'b1);
      if (v !== prev_exp) begin
        ent.cyc = t0 + r;
        ent.v   = v;
        q.push_back(ent);
        prev_exp = v;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.mode_i = 2'b00;
    bus.master_id_i = '0;
    bus.halted_i = '0;
    bus.intc_ack_i = '0;
    bus.exit_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (act !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_state got=%b required=%b", act, 13'b0);
    end
    prev_exp = '0;
    mon_en = 1'b1;

    dd = '{0, 0, 5}; ee = '{0, 0, 2}; run_scn(1, 1, 2, -1);
    dd = '{0, 1, 4}; ee = '{3, 3, 3}; run_scn(2, 0, 1, -1);
    dd = '{20, 20, 20}; ee = '{0, 0, 0}; run_scn(1, 0, 2, -1);
    dd = '{7, 3, 0}; ee = '{2, 7, 7}; run_scn(2, 2, 0, -1);
    dd = '{1, 0, 0}; ee = '{8, 0, 0}; run_scn(1, 2, 1, -1);
    run_scn(0, 0, 0, -1);
    run_scn(3, 1, 0, -1);
    run_scn(1, 3, 0, -1);
    run_scn(2, 3, 0, -1);
    dd = '{0, 0, 1}; ee = '{9, 9, 9}; run_scn(1, 1, 0, 5);
    dd = '{0, 0, 5}; ee = '{0, 0, 2}; run_scn(1, 1, 2, -1);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NC; i++) begin
        dd[i] = $urandom_range(0, 9);
        ee[i] = $urandom_range(0, 9);
      end
      run_scn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.exit_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_changes got=%0d outstanding required=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
